score_digit_scheduler: RTL and testbench



---
 rtl/score_digit_scheduler.sv | 157 +++++++++++++++
 tb/tb_score_digit_scheduler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/score_digit_scheduler.sv
// Decimal score readout through one shared numbers sprite: sequential
// double-dabble conversion, frame-aligned commit and per-column digit selection.
module score_digit_scheduler #(
  parameter int VALUE_WIDTH = 14,
  parameter int NUM_DIGITS  = 4,
  parameter int WIDTH       = 24,
  parameter int HEIGHT      = 24,
  parameter int GAP         = 8,
  parameter int PIPE_LAG    = 4,
  parameter int X_POS       = 100,
  parameter int Y_POS       = 40
) (
  input  logic                   pixel_clk_in,
  input  logic                   rst_in,
  input  logic [VALUE_WIDTH-1:0] value_in,
  input  logic                   value_valid_in,
  output logic                   value_ready_out,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  output logic [10:0]            digit_x_out,
  output logic [9:0]             digit_y_out,
  output logic [3:0]             number_out,
  output logic                   digit_blank_out,
  output logic                   busy_out
);

  localparam int PITCH   = WIDTH + GAP;
  localparam int NB_CALC = (VALUE_WIDTH * 30103 + 99999) / 100000;
  localparam int NB      = (NB_CALC > NUM_DIGITS) ? NB_CALC : NUM_DIGITS;
  localparam int CW      = $clog2(VALUE_WIDTH + 1);
  localparam int IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (GAP < PIPE_LAG || HEIGHT < 1) begin : g_cfg_check
    $error("score_digit_scheduler: GAP must be >= PIPE_LAG and HEIGHT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_DONE} state_t;

  state_t                         state;
  logic [VALUE_WIDTH-1:0]         bin_sr;
  logic [NB*4-1:0]                bcd;
  logic [CW-1:0]                  count;
  logic [NUM_DIGITS-1:0][3:0]     pending;
  logic [NUM_DIGITS-1:0][3:0]     display;
  logic                           pending_flag;
  logic [IDXW-1:0]                idx;

  logic [NB*4-1:0]                bcd_adj;
  logic [NB*4-1:0]                bcd_next;
  logic [VALUE_WIDTH-1:0]         bin_next;
  logic                           saturate;
  logic [NUM_DIGITS-1:0][3:0]     result;
  logic [NUM_DIGITS-1:0]          lead_zero;
  logic                           lz;
  logic [31:0]                    switch_col;
  logic                           commit;

  // Add-3 correction followed by the combined {bcd,bin} left shift.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned k = 0; k < NB; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[NB*4-2:0], bin_sr[VALUE_WIDTH-1]};
    bin_next = {bin_sr[VALUE_WIDTH-2:0], 1'b0};
  end

  // Result array is MSD-first; anything that overflows the display reads as all 9s.
  always_comb begin
    saturate = 1'b0;
    for (int unsigned k = NUM_DIGITS; k < NB; k++) begin
      if (bcd[4*k +: 4] != 4'd0) saturate = 1'b1;
    end
    result = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      result[i] = saturate ? 4'd9 : bcd[4*(NUM_DIGITS-1-i) +: 4];
    end
  end

  assign commit = (hcount_in == 11'd0) && (vcount_in == 10'd0) && pending_flag;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= S_IDLE;
      value_ready_out <= 1'b1;
      bin_sr          <= '0;
      bcd             <= '0;
      count           <= '0;
      pending         <= '0;
      display         <= '0;
      pending_flag    <= 1'b0;
    end else begin
      if (commit) begin
        display      <= pending;
        pending_flag <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (value_valid_in) begin
            bin_sr          <= value_in;
            bcd             <= '0;
            count           <= '0;
            state           <= S_CONVERT;
            value_ready_out <= 1'b0;
          end
        end
        S_CONVERT: begin
          bcd    <= bcd_next;
          bin_sr <= bin_next;
          count  <= count + 1'b1;
          if (count == CW'(VALUE_WIDTH - 1)) state <= S_DONE;
        end
        S_DONE: begin
          // Overrides a same-cycle commit clear: the new result stays pending.
          pending         <= result;
          pending_flag    <= 1'b1;
          state           <= S_IDLE;
          value_ready_out <= 1'b1;
        end
        default: begin
          state           <= S_IDLE;
          value_ready_out <= 1'b1;
        end
      endcase
    end
  end

  assign busy_out = (state != S_IDLE) || pending_flag;

  // Hand over to the next digit once the previous one's lagged pixels are out.
  assign switch_col = 32'(X_POS + WIDTH + PIPE_LAG - 1) + 32'(idx) * 32'(PITCH);

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx <= '0;
    end else if (hcount_in == 11'd0) begin
      idx <= '0;
    end else if ((32'(idx) < 32'(NUM_DIGITS - 1)) && (32'(hcount_in) == switch_col)) begin
      idx <= idx + 1'b1;
    end
  end

  always_comb begin
    lz        = 1'b1;
    lead_zero = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      lz           = lz && (display[i] == 4'd0);
      lead_zero[i] = lz;
    end
  end

  assign digit_x_out     = 11'(32'(X_POS) + 32'(idx) * 32'(PITCH));
  assign digit_y_out     = 10'(Y_POS);
  assign number_out      = display[idx];
  assign digit_blank_out = (32'(idx) < 32'(NUM_DIGITS - 1)) && lead_zero[idx];

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Directed bench for score_digit_scheduler: handshake timing, BCD display,
// blanking, saturation, digit switch columns, commit collisions and reset.
module tb_score_digit_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] value_in;
  logic        value_valid_in;
  logic        value_ready_out;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [10:0] digit_x_out;
  logic [9:0]  digit_y_out;
  logic [3:0]  number_out;
  logic        digit_blank_out;
  logic        busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_digit_scheduler #(
    .VALUE_WIDTH(14), .NUM_DIGITS(4), .WIDTH(24), .HEIGHT(24),
    .GAP(8), .PIPE_LAG(4), .X_POS(100), .Y_POS(40)
  ) dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .value_in       (value_in),
    .value_valid_in (value_valid_in),
    .value_ready_out(value_ready_out),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .digit_x_out    (digit_x_out),
    .digit_y_out    (digit_y_out),
    .number_out     (number_out),
    .digit_blank_out(digit_blank_out),
    .busy_out       (busy_out)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!value_ready_out && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val(tag, 0, 1);
  endtask

  task automatic send(input int v);
    wait_ready("ready_before_send");
    value_in       = 14'(v);
    value_valid_in = 1'b1;
    tick();
    value_valid_in = 1'b0;
    wait_ready("ready_after_send");
  endtask

  task automatic frame_commit();
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    tick();
    hcount_in = 11'd500;
    vcount_in = 10'd5;
  endtask

  // dig: MSD-first nibbles; blk[3] is idx 0.
  task automatic scan_line(input string tag, input logic [15:0] dig, input logic [3:0] blk);
    int k;
    hcount_in = 11'd0;
    tick();
    for (int h = 1; h <= 228; h++) begin
      hcount_in = 11'(h);
      #1;
      k = 0;
      if (h > 127) k++;
      if (h > 159) k++;
      if (h > 191) k++;
      check_val({tag, "_x"}, 32'(digit_x_out), 32'(100 + 32 * k));
      if (h == 110 || h == 145 || h == 175 || h == 210) begin
        check_val({tag, "_num"}, 32'(number_out), 32'(dig[15-4*k -: 4]));
        check_val({tag, "_blank"}, 32'(digit_blank_out), 32'(blk[3-k]));
        check_val({tag, "_y"}, 32'(digit_y_out), 40);
      end
      tick();
    end
    hcount_in = 11'd500;
  endtask

  initial begin
    rst            = 1'b1;
    value_in       = '0;
    value_valid_in = 1'b0;
    hcount_in      = 11'd500;
    vcount_in      = 10'd5;
    #1;
    check_val("rst_ready", 32'(value_ready_out), 1);
    check_val("rst_busy", 32'(busy_out), 0);
    check_val("rst_num", 32'(number_out), 0);
    check_val("rst_x", 32'(digit_x_out), 100);
    check_val("rst_blank", 32'(digit_blank_out), 1);
    tick();
    tick();
    rst = 1'b0;
    frame_commit();
    scan_line("idle_line", 16'h0000, 4'b1110);

    // 1234: handshake timing and deferred display
    value_in       = 14'd1234;
    value_valid_in = 1'b1;
    tick();
    value_valid_in = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      check_val("conv_ready_low", 32'(value_ready_out), 0);
      tick();
    end
    check_val("conv_ready_back", 32'(value_ready_out), 1);
    check_val("pending_busy", 32'(busy_out), 1);
    scan_line("before_commit", 16'h0000, 4'b1110);
    frame_commit();
    check_val("after_commit_busy", 32'(busy_out), 0);
    scan_line("v1234", 16'h1234, 4'b0000);

    send(7);    frame_commit(); scan_line("v7", 16'h0007, 4'b1110);
    send(1005); frame_commit(); scan_line("v1005", 16'h1005, 4'b0000);
    send(9999); frame_commit(); scan_line("v9999", 16'h9999, 4'b0000);
    send(0);    frame_commit(); scan_line("v0", 16'h0000, 4'b1110);
    send(12345); frame_commit(); scan_line("sat12345", 16'h9999, 4'b0000);
    send(42);    frame_commit(); scan_line("v42", 16'h0042, 4'b1100);
    send(16383); frame_commit(); scan_line("sat16383", 16'h9999, 4'b0000);

    // DONE on the commit cycle with valid held high throughout
    send(42);
    check_val("pend42_busy", 32'(busy_out), 1);
    value_in       = 14'd1111;
    value_valid_in = 1'b1;
    tick();
    value_in = 14'd3333;
    for (int i = 1; i <= 14; i++) begin
      check_val("held_valid_ready", 32'(value_ready_out), 0);
      tick();
    end
    hcount_in = 11'd0;
    vcount_in = 10'd0;
    tick();
    value_valid_in = 1'b0;
    hcount_in      = 11'd500;
    vcount_in      = 10'd5;
    check_val("collide_ready", 32'(value_ready_out), 1);
    check_val("collide_busy", 32'(busy_out), 1);
    scan_line("collide_old", 16'h0042, 4'b1100);
    frame_commit();
    check_val("collide_commit_busy", 32'(busy_out), 0);
    scan_line("collide_new", 16'h1111, 4'b0000);

    // Reset mid-conversion with another value pending
    send(2222);
    value_in       = 14'd5678;
    value_valid_in = 1'b1;
    tick();
    value_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_val("mid_rst_ready", 32'(value_ready_out), 1);
    check_val("mid_rst_busy", 32'(busy_out), 0);
    check_val("mid_rst_x", 32'(digit_x_out), 100);
    check_val("mid_rst_num", 32'(number_out), 0);
    check_val("mid_rst_blank", 32'(digit_blank_out), 1);
    tick();
    rst = 1'b0;
    frame_commit();
    check_val("post_rst_busy", 32'(busy_out), 0);
    scan_line("post_rst", 16'h0000, 4'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
